alu_exec_serial: RTL

- Execute-stage ALU that consumes the control bundle from the ALU control decoder (aluOp, invA, invB, Cin, sign, rorSel) and performs the operation on two 16-bit operands.
- Add and logic ops complete in one cycle. Shifts and rotates run iteratively, one bit position per cycle, through a serial shifter.
- Upstream uses a valid/ready handshake on input and output, so the pipeline stalls for the duration of a multi-cycle shift.

---
 rtl/alu_exec_serial.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_serial.sv
// Execute-stage ALU: single-cycle add/logic ops, serial one-bit-per-cycle shifter
// for shifts and rotates, valid/ready handshake on both sides.
module alu_exec_serial #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   aluOp,
  input  logic         invA,
  input  logic         invB,
  input  logic         Cin,
  input  logic         sign,
  input  logic         rorSel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         ofl,
  output logic         carry
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  shReg_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    opReg_r;
  logic          rorReg_r;

  logic [N-1:0]  aiS;
  logic [N-1:0]  biS;
  logic [N:0]    sumS;
  logic          signedOflS;
  logic [N-1:0]  immResultS;
  logic          immOflS;
  logic          immCarryS;
  logic [N-1:0]  shNextS;
  logic [CW-1:0] shAmtS;

  // One position of the serial shifter; op selects direction and fill.
  function automatic logic [N-1:0] shiftStep(
    input logic [N-1:0] v,
    input logic [1:0]   op,
    input logic         ror
  );
    logic [N-1:0] r;
    case (op)
      2'b00:   r = {v[N-2:0], v[N-1]};
      2'b01:   r = {v[N-2:0], 1'b0};
      2'b10:   r = ror ? {v[0], v[N-1:1]} : {v[N-1], v[N-1:1]};
      2'b11:   r = {1'b0, v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic isZero(input logic [N-1:0] v);
    return (v == {N{1'b0}});
  endfunction

  // Operand preparation and single-cycle datapath evaluated on the live inputs.
  always_comb begin
    aiS        = invA ? ~A : A;
    biS        = invB ? ~B : B;
    shAmtS     = B[CW-1:0];
    sumS       = {1'b0, aiS} + {1'b0, biS} + {{N{1'b0}}, Cin};
    signedOflS = (aiS[N-1] == biS[N-1]) && (sumS[N-1] != aiS[N-1]);
    immResultS = aiS;
    immOflS    = 1'b0;
    immCarryS  = 1'b0;
    case (aluOp)
      3'b100: begin
        immResultS = sumS[N-1:0];
        immCarryS  = sumS[N];
        if (sign) begin
          immOflS = signedOflS;
        end else begin
          immOflS = sumS[N];
        end
      end
      3'b101:  immResultS = aiS | biS;
      3'b110:  immResultS = aiS ^ biS;
      3'b111:  immResultS = aiS & biS;
      // Shift opcodes land here only when the amount is zero: pass Ai through.
      default: immResultS = aiS;
    endcase
  end

  // Next value of the serial shift register.
  always_comb begin
    shNextS = shiftStep(shReg_r, opReg_r, rorReg_r);
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= {N{1'b0}};
      zero      <= 1'b0;
      ofl       <= 1'b0;
      carry     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      shReg_r   <= {N{1'b0}};
      opReg_r   <= 2'b00;
      rorReg_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            opReg_r  <= aluOp[1:0];
            rorReg_r <= rorSel;
            shReg_r  <= aiS;
            in_ready <= 1'b0;
            if (aluOp[2] || (shAmtS == {CW{1'b0}})) begin
              result    <= immResultS;
              zero      <= isZero(immResultS);
              ofl       <= immOflS;
              carry     <= immCarryS;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              cnt_r   <= shAmtS;
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shReg_r <= shNextS;
          cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          // Last step: publish the shifted value directly, no extra cycle.
          if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
            result    <= shNextS;
            zero      <= isZero(shNextS);
            ofl       <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cnt_r     <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
